// File: rtl/wbarb_timeout_if.sv
// Pipelined Wishbone bus bundle used on both master-facing and slave-facing sides.
// Pure wiring, no latency.
// Backpressure travels slave-to-master on stall; ack/err/rdat are slave responses.
interface wbarb_timeout_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdat;
    logic [DW/8-1:0] sel;
    logic            stall;
    logic            ack;
    logic            err;
    logic [DW-1:0]   rdat;

    // Side that issues requests and consumes responses
    modport master (
        output cyc, stb, we, addr, wdat, sel,
        input  stall, ack, err, rdat
    );

    // Side that accepts requests and produces responses
    modport slave (
        input  cyc, stb, we, addr, wdat, sel,
        output stall, ack, err, rdat
    );
endinterface

// File: rtl/wbarb_timeout.sv
// Two-master round-robin Wishbone arbiter with a bus-cycle timeout watchdog.
// Grant latency one cycle; the owner's request path and all responses are combinational.
// Non-owners see stall=1; an aborted owner sees stall=0 and an err pulse so it never hangs.
module wbarb_timeout #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    wbarb_timeout_if.slave  a_bus,
    wbarb_timeout_if.slave  b_bus,
    wbarb_timeout_if.master s_bus
);

    localparam int             CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);
    localparam bit             WD_EN    = (TIMEOUT > 0);
    localparam logic           LAST_A   = 1'b0;
    localparam logic           LAST_B   = 1'b1;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          aborted_q, aborted_d;

    logic            owned;
    logic            sel_b;
    logic            own_cyc;
    logic            own_stb;
    logic            own_we;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_wdat;
    logic [DW/8-1:0] own_sel;
    logic            hold;
    logic            to_pulse;
    logic            abort_now;

    // Request mux from the current owner and the watchdog abort decision
    always_comb begin
        owned    = (owner_q != OWN_IDLE);
        sel_b    = (owner_q == OWN_B);
        own_cyc  = sel_b ? b_bus.cyc  : a_bus.cyc;
        own_stb  = sel_b ? b_bus.stb  : a_bus.stb;
        own_we   = sel_b ? b_bus.we   : a_bus.we;
        own_addr = sel_b ? b_bus.addr : a_bus.addr;
        own_wdat = sel_b ? b_bus.wdat : a_bus.wdat;
        own_sel  = sel_b ? b_bus.sel  : a_bus.sel;
        hold     = owned && own_cyc;
        // The abort takes effect in the very cycle the err pulse is shown,
        // so the slave loses cyc together with the err reaching the master.
        to_pulse = WD_EN && hold && !aborted_q && !s_bus.ack && !s_bus.err
                   && (cnt_q == CNT_LAST);
        abort_now = aborted_q || to_pulse;
    end

    // Ownership state: grant, release/handoff and watchdog counting
    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;

        unique case (owner_q)
            OWN_IDLE: begin
                if (a_bus.cyc && (!b_bus.cyc || (last_q == LAST_B))) begin
                    owner_d   = OWN_A;
                    last_d    = LAST_A;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end else if (b_bus.cyc) begin
                    owner_d   = OWN_B;
                    last_d    = LAST_B;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            OWN_A: begin
                if (!a_bus.cyc) begin
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    if (b_bus.cyc) begin
                        owner_d = OWN_B;
                        last_d  = LAST_B;
                    end else begin
                        owner_d = OWN_IDLE;
                    end
                end
            end
            OWN_B: begin
                if (!b_bus.cyc) begin
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                    if (a_bus.cyc) begin
                        owner_d = OWN_A;
                        last_d  = LAST_A;
                    end else begin
                        owner_d = OWN_IDLE;
                    end
                end
            end
            default: begin
                owner_d = OWN_IDLE;
            end
        endcase

        if (hold && WD_EN) begin
            if (s_bus.ack || s_bus.err) begin
                cnt_d = '0;
            end else if (!abort_now && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (to_pulse) begin
                aborted_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; B counts as last so A wins the first tie
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            owner_q   <= OWN_IDLE;
            last_q    <= LAST_B;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    // Slave request drive and per-master response steering
    always_comb begin
        s_bus.cyc  = owned && own_cyc && !abort_now;
        s_bus.stb  = owned && own_stb && !abort_now;
        s_bus.we   = owned ? own_we   : 1'b0;
        s_bus.addr = owned ? own_addr : '0;
        s_bus.wdat = owned ? own_wdat : '0;
        s_bus.sel  = owned ? own_sel  : '0;

        a_bus.rdat  = s_bus.rdat;
        b_bus.rdat  = s_bus.rdat;

        a_bus.stall = 1'b1;
        a_bus.ack   = 1'b0;
        a_bus.err   = 1'b0;
        b_bus.stall = 1'b1;
        b_bus.ack   = 1'b0;
        b_bus.err   = 1'b0;

        if (owner_q == OWN_A) begin
            a_bus.stall = s_bus.stall && !abort_now;
            a_bus.ack   = s_bus.ack && !aborted_q;
            a_bus.err   = (s_bus.err && !aborted_q) || to_pulse;
        end else if (owner_q == OWN_B) begin
            b_bus.stall = s_bus.stall && !abort_now;
            b_bus.ack   = s_bus.ack && !aborted_q;
            b_bus.err   = (s_bus.err && !aborted_q) || to_pulse;
        end
    end

endmodule

// File: tb/tb_wbarb_timeout.sv
// Directed bench for wbarb_timeout: stimulus pushes expected slave requests and
// master responses into queues; a negedge monitor pops and compares them.
// Main instance uses TIMEOUT=8, a second instance uses TIMEOUT=0.
module tb_wbarb_timeout;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    wbarb_timeout_if #(.AW(30), .DW(32)) ma ();
    wbarb_timeout_if #(.AW(30), .DW(32)) mb ();
    wbarb_timeout_if #(.AW(30), .DW(32)) sl ();
    wbarb_timeout_if #(.AW(30), .DW(32)) za ();
    wbarb_timeout_if #(.AW(30), .DW(32)) zb ();
    wbarb_timeout_if #(.AW(30), .DW(32)) zs ();

    wbarb_timeout #(.AW(30), .DW(32), .TIMEOUT(8)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .a_bus     (ma),
        .b_bus     (mb),
        .s_bus     (sl)
    );

    wbarb_timeout #(.AW(30), .DW(32), .TIMEOUT(0)) dut0 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .a_bus     (za),
        .b_bus     (zb),
        .s_bus     (zs)
    );

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic [31:0] dat;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   z_events = 0;

    task automatic checkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [29:0] a, input logic we, input logic [31:0] d);
        req_t r;
        r.addr = a; r.we = we; r.dat = d;
        req_q.push_back(r);
    endtask

    task automatic push_rsp(input logic m, input logic e, input logic [31:0] d);
        rsp_t r;
        r.m = m; r.err = e; r.dat = d;
        rsp_q.push_back(r);
    endtask

    task automatic chk_rsp(input logic m, input logic e, input logic [31:0] d);
        rsp_t x;
        if (rsp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_unexpected: got master %0d err %b data %h, none expected at %0t",
                     m, e, d, $time);
        end else begin
            x = rsp_q.pop_front();
            checkw("rsp", 64'({m, e, d}), 64'({x.m, x.err, x.dat}));
        end
    endtask

    // Monitor: every response and every accepted slave request is matched against the queues
    always @(negedge clk) begin
        req_t r;
        if (ma.ack || ma.err) chk_rsp(1'b0, ma.err, ma.rdat);
        if (mb.ack || mb.err) chk_rsp(1'b1, mb.err, mb.rdat);
        if (sl.cyc && sl.stb && !sl.stall) begin
            if (req_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL req_unexpected: got addr %h we %b, none expected at %0t",
                         sl.addr, sl.we, $time);
            end else begin
                r = req_q.pop_front();
                checkw("req", 64'({sl.addr, sl.we, sl.wdat}), 64'({r.addr, r.we, r.dat}));
            end
        end
        if (za.ack || za.err || zb.ack || zb.err) z_events++;
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        ma.cyc = 0; ma.stb = 0; ma.we = 0; ma.addr = '0; ma.wdat = '0; ma.sel = '0;
        mb.cyc = 0; mb.stb = 0; mb.we = 0; mb.addr = '0; mb.wdat = '0; mb.sel = '0;
        za.cyc = 0; za.stb = 0; za.we = 0; za.addr = '0; za.wdat = '0; za.sel = '0;
        zb.cyc = 0; zb.stb = 0; zb.we = 0; zb.addr = '0; zb.wdat = '0; zb.sel = '0;
        sl.stall = 0; sl.ack = 0; sl.err = 0; sl.rdat = '0;
        zs.stall = 1; zs.ack = 0; zs.err = 0; zs.rdat = '0;
        repeat (3) nx();
        rst_n = 1'b1;
        mid();
        // Reset / idle outputs
        check1("rst_cyc", sl.cyc, 1'b0);
        check1("rst_stb", sl.stb, 1'b0);
        check1("rst_we", sl.we, 1'b0);
        check1("rst_a_stall", ma.stall, 1'b1);
        check1("rst_b_stall", mb.stall, 1'b1);
        checkw("rst_resp", 64'({ma.ack, ma.err, mb.ack, mb.err}), 64'(0));

        // Single A read
        nx();
        ma.cyc = 1; ma.stb = 1; ma.we = 0; ma.addr = 30'h100; ma.sel = 4'hF;
        mid();
        check1("rd_a_stall_t0", ma.stall, 1'b1);
        check1("rd_cyc_t0", sl.cyc, 1'b0);
        nx();
        push_req(30'h100, 1'b0, 32'h0);
        mid();
        check1("rd_cyc_t1", sl.cyc, 1'b1);
        check1("rd_a_stall_t1", ma.stall, 1'b0);
        nx();
        ma.stb = 0; sl.ack = 1; sl.rdat = 32'hDEADBEEF;
        push_rsp(1'b0, 1'b0, 32'hDEADBEEF);
        mid();
        nx();
        sl.ack = 0; ma.cyc = 0;
        mid();
        check1("rd_cyc_drop", sl.cyc, 1'b0);
        nx();
        mid();
        check1("rd_idle_stall", ma.stall, 1'b1);

        // Simultaneous request after reset
        rst_n = 1'b0;
        nx();
        rst_n = 1'b1;
        ma.cyc = 1; ma.stb = 1; ma.we = 1; ma.addr = 30'h200; ma.wdat = 32'h11111111;
        mb.cyc = 1; mb.stb = 1; mb.we = 0; mb.addr = 30'h300; mb.wdat = 32'h0;
        mid();
        checkw("tie_stalls_t0", 64'({ma.stall, mb.stall}), 64'(2'b11));
        nx();
        push_req(30'h200, 1'b1, 32'h11111111);
        mid();
        check1("tie_a_granted", ma.stall, 1'b0);
        check1("tie_b_waits", mb.stall, 1'b1);
        nx();
        ma.stb = 0; sl.ack = 1; sl.rdat = 32'h0;
        push_rsp(1'b0, 1'b0, 32'h0);
        mid();
        nx();
        sl.ack = 0; ma.cyc = 0;
        mid();
        nx();
        push_req(30'h300, 1'b0, 32'h0);
        mid();
        check1("handoff_cyc", sl.cyc, 1'b1);
        check1("handoff_b_stall", mb.stall, 1'b0);
        nx();
        mb.stb = 0; sl.ack = 1; sl.rdat = 32'hCAFEF00D;
        push_rsp(1'b1, 1'b0, 32'hCAFEF00D);
        mid();
        nx();
        sl.ack = 0; mb.cyc = 0;
        nx();
        ma.cyc = 1; ma.stb = 1; ma.we = 0; ma.addr = 30'h204; ma.wdat = 32'h0;
        mb.cyc = 1; mb.stb = 1; mb.addr = 30'h304;
        nx();
        push_req(30'h204, 1'b0, 32'h0);
        mid();
        check1("rr_a_again", ma.stall, 1'b0);
        check1("rr_b_waits", mb.stall, 1'b1);
        nx();
        ma.stb = 0; sl.ack = 1; sl.rdat = 32'h12345678;
        push_rsp(1'b0, 1'b0, 32'h12345678);
        nx();
        sl.ack = 0; ma.cyc = 0; mb.cyc = 0; mb.stb = 0;
        nx();

        // B owns with three pipelined strobes; A requests mid-cycle
        mb.cyc = 1; mb.stb = 1; mb.we = 0; mb.addr = 30'h400;
        nx();
        push_req(30'h400, 1'b0, 32'h0);
        mid();
        check1("pipe_b_cyc", sl.cyc, 1'b1);
        for (int k = 0; k < 3; k++) begin
            nx();
            if (k < 2) begin
                mb.addr = 30'h401 + 30'(k);
                push_req(30'h401 + 30'(k), 1'b0, 32'h0);
            end else begin
                mb.stb = 0;
            end
            sl.ack = 1; sl.rdat = 32'hB0 + 32'(k);
            push_rsp(1'b1, 1'b0, 32'hB0 + 32'(k));
            if (k == 0) begin
                ma.cyc = 1; ma.stb = 1; ma.we = 0; ma.addr = 30'h500;
            end
            mid();
            check1("pipe_a_stall", ma.stall, 1'b1);
        end
        nx();
        sl.ack = 0; mb.cyc = 0;
        mid();
        check1("pipe_a_stall_rel", ma.stall, 1'b1);
        nx();
        push_req(30'h500, 1'b0, 32'h0);
        mid();
        check1("pipe_a_granted", ma.stall, 1'b0);
        nx();
        ma.stb = 0; sl.ack = 1; sl.rdat = 32'hA5;
        push_rsp(1'b0, 1'b0, 32'hA5);
        nx();
        sl.ack = 0; ma.cyc = 0;
        nx();

        // Watchdog: A write never acknowledged
        sl.rdat = 32'h0;
        ma.cyc = 1; ma.stb = 1; ma.we = 1; ma.addr = 30'h600; ma.wdat = 32'h55;
        nx();
        push_req(30'h600, 1'b1, 32'h55);
        mid();
        check1("to_cyc_t1", sl.cyc, 1'b1);
        for (int k = 2; k <= 7; k++) begin
            nx();
            if (k == 2) ma.stb = 0;
            mid();
            check1("to_cyc_open", sl.cyc, 1'b1);
        end
        nx();
        push_rsp(1'b0, 1'b1, 32'h0);
        mid();
        check1("to_cyc_drop", sl.cyc, 1'b0);
        nx();
        sl.ack = 1;
        mid();
        check1("to_aborted_cyc", sl.cyc, 1'b0);
        check1("to_aborted_stall", ma.stall, 1'b0);
        nx();
        sl.ack = 0; ma.cyc = 0;
        nx();
        mid();
        check1("to_idle_stall", ma.stall, 1'b1);
        nx();
        ma.cyc = 1; ma.stb = 1; ma.we = 0; ma.addr = 30'h700; ma.wdat = 32'h0;
        nx();
        push_req(30'h700, 1'b0, 32'h0);
        mid();
        check1("to_regrant_cyc", sl.cyc, 1'b1);
        nx();
        ma.stb = 0; sl.ack = 1; sl.rdat = 32'h77;
        push_rsp(1'b0, 1'b0, 32'h77);
        nx();
        sl.ack = 0; ma.cyc = 0;
        nx();

        // Reset during a B-owned cycle
        mb.cyc = 1; mb.stb = 1; mb.we = 0; mb.addr = 30'h800;
        nx();
        push_req(30'h800, 1'b0, 32'h0);
        mid();
        check1("rstmid_b_cyc", sl.cyc, 1'b1);
        nx();
        mb.stb = 0; rst_n = 1'b0;
        nx();
        rst_n = 1'b1;
        ma.cyc = 1; ma.stb = 1; ma.we = 0; ma.addr = 30'h900;
        mb.stb = 1;
        mid();
        check1("rstmid_cyc", sl.cyc, 1'b0);
        checkw("rstmid_stalls", 64'({ma.stall, mb.stall}), 64'(2'b11));
        nx();
        push_req(30'h900, 1'b0, 32'h0);
        mid();
        check1("rstmid_a_wins", ma.stall, 1'b0);
        check1("rstmid_b_waits", mb.stall, 1'b1);
        nx();
        ma.stb = 0; mb.cyc = 0; mb.stb = 0; sl.ack = 1; sl.rdat = 32'h99;
        push_rsp(1'b0, 1'b0, 32'h99);
        nx();
        sl.ack = 0; ma.cyc = 0;
        nx();

        // Watchdog disabled: slave stalls for 5000 cycles
        za.cyc = 1; za.stb = 1; za.we = 0; za.addr = 30'h10;
        repeat (5000) nx();
        mid();
        checkw("wd0_no_err", 64'(z_events), 64'(0));
        check1("wd0_cyc_open", zs.cyc, 1'b1);
        check1("wd0_stb_open", zs.stb, 1'b1);
        check1("wd0_stall", za.stall, 1'b1);
        nx();
        za.cyc = 0; za.stb = 0;
        repeat (2) nx();
        mid();

        checkw("rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        checkw("req_q_empty", 64'(req_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
